// File: rtl/basic_cpu_pkg.sv
// Shared definitions for the basic computer's control and datapath modules.
// Contents:
//   state_t       timing-state encoding of the fetch sequencer
//   IND_BIT       IR bit that holds the indirect flag
//   OPC_LO/OPC_HI IR bit range that holds the opcode
//   OPC_REGREF    opcode value for register-reference / IO instructions
//   state_onehot  state_t -> one-hot {EXEC,T3,T2,T1,T0,HALT}
package basic_cpu_pkg;

   typedef enum logic [2:0] {
      S_HALT = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_EXEC = 3'd5
   } state_t;

   localparam int          IND_BIT    = 15;
   localparam int          OPC_LO     = 12;
   localparam int          OPC_HI     = 14;
   localparam logic [2:0]  OPC_REGREF = 3'd7;

   // The encoding order matches the t_state bit order, so a shift gives the one-hot value.
   function automatic logic [5:0] state_onehot(input state_t s);
      return 6'(1) << s;
   endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder. Produces the one-hot D0..D(2**OPC_W-1) lines.
// Ports:
//   opc  in   OPC_W        opcode field
//   dec  out  2**OPC_W     one-hot decode. dec[opc] = 1
module opcode_decoder #(
   parameter int OPC_W = 3
) (
   input  logic [OPC_W-1:0]      opc,
   output logic [(1<<OPC_W)-1:0] dec
);

   always_comb begin
      dec      = '0;
      dec[opc] = 1'b1;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Timing/control unit of the basic computer. Sequences fetch (T0-T1), decode (T2)
// and indirect (T3), then hands off to the execute unit and waits in EXEC
// until that unit reports exec_done. If exec_done never arrives, the EXEC
// watchdog sets fault.
// Ports:
//   clk, rst            clock, async active-high reset
//   run                 level: 1 = keep fetching, 0 = stop at the next instruction boundary
//   ir                  current IR contents
//   exec_done/halt_req  handshake from the execute unit (halt_req is sampled with exec_done)
//   bus_x2/x5/x7        bus source select: PC / IR / memory
//   mem_read, ld_ar, ld_ir, ld_i, pc_incr   fetch-phase strobes
//   exec_start          one-cycle pulse in the first EXEC cycle
//   opcode_dec/indirect decoded IR fields, captured in T2
//   t_state             one-hot {EXEC,T3,T2,T1,T0,HALT}
//   fault               sticky EXEC-timeout flag, cleared only by rst
// Every output is a flop loaded from next-state decode. Outputs are therefore
// glitch-free and have no combinational path from the inputs.
module fetch_sequencer
   import basic_cpu_pkg::*;
#(
   parameter int OPC_W        = 3,
   parameter int IR_W         = 16,
   parameter int EXEC_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic [IR_W-1:0]       ir,
   input  logic                  exec_done,
   input  logic                  halt_req,
   output logic                  bus_x2,
   output logic                  bus_x5,
   output logic                  bus_x7,
   output logic                  mem_read,
   output logic                  ld_ar,
   output logic                  ld_ir,
   output logic                  ld_i,
   output logic                  pc_incr,
   output logic                  exec_start,
   output logic [(1<<OPC_W)-1:0] opcode_dec,
   output logic                  indirect,
   output logic [5:0]            t_state,
   output logic                  fault
);

   localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

   state_t                 state, nxt;
   logic [CNT_W-1:0]       cnt;
   logic                   timeout;
   logic [(1<<OPC_W)-1:0]  dec;
   logic [OPC_W-1:0]       opc;

   assign opc = ir[OPC_HI:OPC_LO];

   opcode_decoder #(.OPC_W(OPC_W)) u_dec (
      .opc (opc),
      .dec (dec)
   );

   // exec_start is high exactly in the first EXEC cycle. It is reused here
   // to mask exec_done in that cycle. cnt is the number of EXEC cycles
   // already completed. In the EXEC_TIMEOUT-th cycle it equals
   // EXEC_TIMEOUT-1.
   always_comb begin
      nxt     = state;
      timeout = 1'b0;
      case (state)
         S_HALT: if (run && !fault) nxt = S_T0;
         S_T0:   nxt = S_T1;
         S_T1:   nxt = S_T2;
         S_T2:   nxt = (ir[IND_BIT] && (opc != OPC_REGREF)) ? S_T3 : S_EXEC;
         S_T3:   nxt = S_EXEC;
         S_EXEC: begin
            if (!exec_start && exec_done)
               nxt = (halt_req || !run) ? S_HALT : S_T0;
            else if (cnt == CNT_W'(EXEC_TIMEOUT - 1)) begin
               nxt     = S_HALT;
               timeout = 1'b1;
            end
         end
         default: nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_HALT;
         t_state    <= 6'b000001;
         cnt        <= '0;
         bus_x2     <= 1'b0;
         bus_x5     <= 1'b0;
         bus_x7     <= 1'b0;
         mem_read   <= 1'b0;
         ld_ar      <= 1'b0;
         ld_ir      <= 1'b0;
         ld_i       <= 1'b0;
         pc_incr    <= 1'b0;
         exec_start <= 1'b0;
         opcode_dec <= '0;
         indirect   <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state      <= nxt;
         t_state    <= state_onehot(nxt);
         // Every non-EXEC state clears the counter, so it restarts at 0 on each EXEC entry.
         cnt        <= (state == S_EXEC) ? cnt + 1'b1 : '0;
         bus_x2     <= (nxt == S_T0);
         bus_x5     <= (nxt == S_T2);
         bus_x7     <= (nxt == S_T1) || (nxt == S_T3);
         mem_read   <= (nxt == S_T1) || (nxt == S_T3);
         ld_ar      <= (nxt == S_T0) || (nxt == S_T2) || (nxt == S_T3);
         ld_ir      <= (nxt == S_T1);
         ld_i       <= (nxt == S_T2);
         pc_incr    <= (nxt == S_T1);
         exec_start <= (nxt == S_EXEC) && (state != S_EXEC);
         fault      <= fault | timeout;
         // IR was loaded at the end of T1, so it is valid to sample throughout T2.
         if (state == S_T2) begin
            opcode_dec <= dec;
            indirect   <= ir[IND_BIT];
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. An instruction-level reference model
// tracks position within the instruction and checks every output each cycle.
// A table of instructions checks per-instruction results. Hand sequences cover
// a stop mid-instruction, the EXEC timeout, and async reset.
module tb_fetch_sequencer;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        exec_done = 1'b0;
   logic        halt_req = 1'b0;
   logic [15:0] ir = '0;
   logic        bus_x2, bus_x5, bus_x7, mem_read, ld_ar, ld_ir, ld_i, pc_incr, exec_start;
   logic [7:0]  opcode_dec;
   logic        indirect, fault;
   logic [5:0]  t_state;

   fetch_sequencer #(.OPC_W(3), .IR_W(16), .EXEC_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .run(run), .ir(ir), .exec_done(exec_done), .halt_req(halt_req),
      .bus_x2(bus_x2), .bus_x5(bus_x5), .bus_x7(bus_x7), .mem_read(mem_read),
      .ld_ar(ld_ar), .ld_ir(ld_ir), .ld_i(ld_i), .pc_incr(pc_incr),
      .exec_start(exec_start), .opcode_dec(opcode_dec), .indirect(indirect),
      .t_state(t_state), .fault(fault)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n_chk = 0;
   int n_pass = 0;
   logic prev_pc = 1'b0;

   // Reference model: halted flag, or cycle position since T0 within the current instruction.
   bit         m_halt = 1'b1;
   bit         m_fault = 1'b0;
   bit         m_ind = 1'b0;
   int         m_pos = 0;
   logic [7:0] m_opc = '0;
   logic       m_ibit = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      m_halt = 1'b1; m_fault = 1'b0; m_ind = 1'b0; m_pos = 0; m_opc = '0; m_ibit = 1'b0;
   endtask

   function automatic int first_exec();
      return m_ind ? 4 : 3;
   endfunction

   // 1-based EXEC cycle number, or 0 when not executing.
   function automatic int exec_n();
      if (m_halt || m_pos < first_exec()) return 0;
      return m_pos - first_exec() + 1;
   endfunction

   task automatic model_edge();
      int n;
      if (m_halt) begin
         if (run && !m_fault) begin m_halt = 1'b0; m_pos = 0; end
      end else begin
         if (m_pos == 2) begin
            m_opc  = 8'd1 << ir[14:12];
            m_ibit = ir[15];
            m_ind  = ir[15] && (ir[14:12] != 3'd7);
         end
         n = exec_n();
         if (n == 0) m_pos++;
         else if (n >= 2 && exec_done) begin
            if (halt_req || !run) m_halt = 1'b1;
            else m_pos = 0;
         end else if (n == TMO) begin
            m_fault = 1'b1; m_halt = 1'b1;
         end else m_pos++;
      end
   endtask

   function automatic logic [24:0] exp_vec();
      int ph;
      logic [8:0] s;
      if (m_halt) ph = 0;
      else if (m_pos < 3) ph = m_pos + 1;
      else if (m_pos == 3 && m_ind) ph = 4;
      else ph = 5;
      // {x2,x5,x7,mem_read,ld_ar,ld_ir,ld_i,pc_incr,exec_start}
      case (ph)
         1:       s = 9'b100010000;
         2:       s = 9'b001101010;
         3:       s = 9'b010010100;
         4:       s = 9'b001110000;
         5:       s = {8'b0, m_pos == first_exec()};
         default: s = 9'b0;
      endcase
      return {s, m_opc, m_ibit, 6'(1 << ph), m_fault};
   endfunction

   function automatic logic [24:0] act_vec();
      return {bus_x2, bus_x5, bus_x7, mem_read, ld_ar, ld_ir, ld_i, pc_incr, exec_start,
              opcode_dec, indirect, t_state, fault};
   endfunction

   task automatic check_cycle();
      chk("outputs_vs_model", 32'(act_vec()), 32'(exp_vec()));
      chk("bus_onehot0", 32'($onehot0({bus_x2, bus_x5, bus_x7})), 32'd1);
      chk("pc_incr_single", 32'(prev_pc & pc_incr), 32'd0);
      prev_pc = pc_incr;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      prev_pc = 1'b0;
      check_cycle();
   endtask

   typedef struct {
      logic [15:0] ir;
      int          d;      // EXEC cycle in which exec_done is given
      logic [7:0]  opc;
      logic        ind;
      logic        t3;
      int          cyc;    // cycles from T0 through the last EXEC cycle
   } vec_t;

   vec_t tv[6];

   initial begin
      tv[0] = '{16'h2005, 2, 8'h04, 1'b0, 1'b0, 5};
      tv[1] = '{16'hA010, 2, 8'h04, 1'b1, 1'b1, 6};
      tv[2] = '{16'h7800, 2, 8'h80, 1'b0, 1'b0, 5};
      tv[3] = '{16'hF800, 2, 8'h80, 1'b1, 1'b0, 5};
      tv[4] = '{16'h0000, 4, 8'h01, 1'b0, 1'b0, 7};
      tv[5] = '{16'hE123, 3, 8'h40, 1'b1, 1'b1, 7};

      do_reset();
      chk("reset_t_state", 32'(t_state), 32'h01);

      // Table: one instruction each, ended by halt_req.
      foreach (tv[i]) begin
         int cyc, pcs;
         bit saw3, started;
         do_reset();
         chk("tbl_opc_cleared", 32'(opcode_dec), 32'h0);
         ir = tv[i].ir; run = 1'b1; halt_req = 1'b1; exec_done = 1'b0;
         cyc = 0; pcs = 0; saw3 = 1'b0; started = 1'b0;
         for (int k = 0; k < 30; k++) begin
            step();
            if (t_state != 6'b000001) begin
               started = 1'b1;
               cyc++;
               if (t_state == 6'b010000) saw3 = 1'b1;
               if (pc_incr) pcs++;
            end else if (started) break;
            exec_done = (exec_n() == tv[i].d);
         end
         run = 1'b0; exec_done = 1'b0;
         chk("tbl_cycles", 32'(cyc), 32'(tv[i].cyc));
         chk("tbl_opcode_dec", 32'(opcode_dec), 32'(tv[i].opc));
         chk("tbl_indirect", 32'(indirect), 32'(tv[i].ind));
         chk("tbl_t3_visited", 32'(saw3), 32'(tv[i].t3));
         chk("tbl_pc_incr_pulses", 32'(pcs), 32'd1);
         step();
         chk("tbl_stays_halt", 32'(t_state), 32'h01);
      end

      // Drop run in T1: the instruction completes, then no new T0.
      do_reset();
      ir = 16'h3001; run = 1'b1; halt_req = 1'b0; exec_done = 1'b0;
      step(); step();
      chk("stop_in_t1_state", 32'(t_state), 32'h04);
      run = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         exec_done = (exec_n() == 3);
      end
      exec_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stop_no_t0", 32'(t_state), 32'h01);
      end

      // EXEC timeout: exec_done held low.
      begin
         int ex;
         do_reset();
         ir = 16'h1000; run = 1'b1; exec_done = 1'b0;
         ex = 0;
         for (int k = 0; k < 400 && !fault; k++) begin
            step();
            if (t_state[5]) ex++;
         end
         chk("tmo_fault", 32'(fault), 32'd1);
         chk("tmo_exec_cycles", 32'(ex), 32'(TMO));
         chk("tmo_halt", 32'(t_state), 32'h01);
         for (int k = 0; k < 5; k++) begin
            step();
            chk("tmo_run_ignored", 32'(t_state), 32'h01);
         end
         do_reset();
         chk("tmo_rst_clears", 32'(fault), 32'd0);
      end

      // Async reset between edges while in T1.
      ir = 16'h2005; run = 1'b1;
      step(); step();
      chk("arst_pre_t1", 32'(t_state), 32'h04);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_immediate", 32'(act_vec()), 32'({9'b0, 8'b0, 1'b0, 6'b000001, 1'b0}));
      run = 1'b0;
      do_reset();

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         run       = ($urandom % 10) != 0;
         ir        = 16'($urandom);
         exec_done = ($urandom % 3) == 0;
         halt_req  = ($urandom % 5) == 0;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
